// File: rtl/core_pkg.sv
// core_pkg: shared RV32I constants and fetch-stage types.
// CORE_IF_MISALIGN_TRAP_EN adds a misaligned-target flag to each fetch entry.
package core_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] BXXX  = 7'b1100011;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALI   = 7'b0010011;
  localparam logic [6:0] ALR   = 7'b0110011;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_t;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
`ifdef CORE_IF_MISALIGN_TRAP_EN
    logic        misalign;
`endif
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/core_if_stage_if.sv
// core_if_stage_if: instruction bus, redirect and decode handshake of the fetch stage.
// CORE_IF_MISALIGN_TRAP_EN adds the o_misalign output.
interface core_if_stage_if;

  logic        o_ibus_rd_req;
  logic [31:0] o_ibus_rd_addr;
  logic        i_ibus_rd_gnt;
  logic [31:0] i_ibus_rd_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_id_stall;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
`ifdef CORE_IF_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  // Fetch stage side
  modport master (
`ifdef CORE_IF_MISALIGN_TRAP_EN
    output o_misalign,
`endif
    output o_ibus_rd_req,
    output o_ibus_rd_addr,
    input  i_ibus_rd_gnt,
    input  i_ibus_rd_data,
    input  i_redirect,
    input  i_redirect_pc,
    input  i_id_stall,
    output o_valid,
    output o_instr,
    output o_pc
  );

  // Memory / pipeline side
  modport slave (
`ifdef CORE_IF_MISALIGN_TRAP_EN
    input  o_misalign,
`endif
    input  o_ibus_rd_req,
    input  o_ibus_rd_addr,
    output i_ibus_rd_gnt,
    output i_ibus_rd_data,
    output i_redirect,
    output i_redirect_pc,
    output i_id_stall,
    input  o_valid,
    input  o_instr,
    input  o_pc
  );

endinterface

// File: rtl/core_if_fifo.sv
// core_if_fifo: synchronous FIFO of fetched {pc, instr} entries with flush.
// A flush in the same cycle as a push leaves exactly the pushed entry.
module core_if_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t      mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop & (count != '0);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush wins over pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; a push during flush lands in slot 0.
  always_ff @(posedge clk) begin
    if (push) mem[flush ? '0 : wr_ptr] <= din;
  end

  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !do_pop && (count == CW'(DEPTH))))
    else $error("core_if_fifo overflow");

endmodule

// File: rtl/core_if_stage.sv
// core_if_stage: RV32I instruction fetch stage (PC, bus requests, fetch queue, redirects).
// Optional: CORE_IF_MISALIGN_TRAP_EN turns a misaligned redirect into a flagged NOP
// entry carrying the raw target PC and halts fetch until the next redirect.
module core_if_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  core_if_stage_if.master bus
);

  localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   redirect_target;
  logic [31:0]   hold_pc;
  logic [31:0]   hold_instr;
  logic          inflight;
  logic          drop;
  logic          req;
  logic          accept;
  logic          pop;
  logic          push;
  logic          valid;
  logic          fetch_enable;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

`ifdef CORE_IF_MISALIGN_TRAP_EN
  logic          halted;
  logic          trap_redirect;

  assign trap_redirect = bus.i_redirect & (bus.i_redirect_pc[1:0] != 2'b00);
  assign fetch_enable  = ~halted;
`else
  assign fetch_enable  = 1'b1;
`endif

  assign valid           = (count != '0);
  assign pop             = valid & ~bus.i_id_stall;
  assign accept          = req & bus.i_ibus_rd_gnt;
  assign redirect_target = bus.i_redirect_pc & ~32'h3;
  // Entries queued plus the response in flight, minus the one leaving this cycle.
  assign occupancy       = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  // Next state and request decision
  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN:  req = ~bus.i_redirect & fetch_enable & (occupancy < DEPTH_LIMIT);
      default: state_next = BOOT;
    endcase
  end

  // Fetch PC, outstanding-response tracking and redirect handling
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= accept;
      drop     <= 1'b0;
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      if (bus.i_redirect) begin
        fetch_pc <= redirect_target;
        drop     <= accept;
      end
    end
  end

`ifdef CORE_IF_MISALIGN_TRAP_EN
  // Fetch halt after a misaligned redirect, released by any later redirect
  always_ff @(posedge clk) begin
    if (rst)                 halted <= 1'b0;
    else if (bus.i_redirect) halted <= trap_redirect;
  end
`endif

  // Queue input: bus response, or the trap NOP on a misaligned redirect
  always_comb begin
    push             = inflight & ~drop & ~bus.i_redirect;
    push_entry       = '0;
    push_entry.pc    = req_pc;
    push_entry.instr = bus.i_ibus_rd_data;
`ifdef CORE_IF_MISALIGN_TRAP_EN
    if (trap_redirect) begin
      push                = 1'b1;
      push_entry.misalign = 1'b1;
      push_entry.pc       = bus.i_redirect_pc;
      push_entry.instr    = INSTR_NOP;
    end
`endif
  end

  core_if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.i_redirect),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  // Last presented instruction, shown again while the queue is empty
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_pc    <= '0;
      hold_instr <= '0;
    end else if (valid) begin
      hold_pc    <= head.pc;
      hold_instr <= head.instr;
    end
  end

  assign bus.o_ibus_rd_req  = req;
  assign bus.o_ibus_rd_addr = fetch_pc;
  assign bus.o_valid        = valid;
  assign bus.o_pc           = valid ? head.pc    : hold_pc;
  assign bus.o_instr        = valid ? head.instr : hold_instr;
`ifdef CORE_IF_MISALIGN_TRAP_EN
  assign bus.o_misalign     = valid & head.misalign;
`endif

endmodule

// File: tb/tb_core_if_stage.sv
// tb_core_if_stage: self-checking bench for core_if_stage.
// The reference is a sequential-PC stream model: every instruction delivered to
// decode must be the next PC of the current stream, carrying the memory word of
// that PC; a redirect restarts the stream at the (word-aligned) target.
`timescale 1ns/1ps
module tb_core_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_if_stage_if bus();

  core_if_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_pc;
  logic [63:0] popped[$];

  logic        s_valid;
  logic        s_req;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  logic [31:0] s_addr;
`ifdef CORE_IF_MISALIGN_TRAP_EN
  logic        s_mis;
`endif

  // Instruction memory contents seen by the fetch stage
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], 16'h0000};
  endfunction

  // Bus slave: data one cycle after an accepted request, junk otherwise
  always @(posedge clk) begin
    if (bus.o_ibus_rd_req && bus.i_ibus_rd_gnt)
      bus.i_ibus_rd_data <= mem_word(bus.o_ibus_rd_addr);
    else
      bus.i_ibus_rd_data <= $urandom;
  end

  // One cycle: drive inputs at negedge, sample outputs 1ns later, log a pop
  task automatic tick(input logic r, input logic redir, input logic [31:0] rpc,
                      input logic stall, input logic gnt);
    @(negedge clk);
    rst               = r;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = rpc;
    bus.i_id_stall    = stall;
    bus.i_ibus_rd_gnt = gnt;
    #1;
    s_valid = bus.o_valid;
    s_req   = bus.o_ibus_rd_req;
    s_pc    = bus.o_pc;
    s_instr = bus.o_instr;
    s_addr  = bus.o_ibus_rd_addr;
`ifdef CORE_IF_MISALIGN_TRAP_EN
    s_mis   = bus.o_misalign;
`endif
    if (!r && !redir && !stall && s_valid) popped.push_back({s_pc, s_instr});
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b0 || s_pc !== 32'h0 || s_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: valid=%b req=%b pc=%h instr=%h, required 0 0 0 0",
               s_valid, s_req, s_pc, s_instr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (s_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req: req=%b, required 0", s_req);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h, required 1 00000000", s_req, s_addr);
    end
    exp_pc = 32'h0;
    popped.delete();
  endtask

  task automatic test_stream();
    logic [63:0] e;
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h4) begin
      errors++;
      $display("FAIL stream_second_req: valid=%b req=%b addr=%h, required 0 1 00000004",
               s_valid, s_req, s_addr);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== 32'h0 || s_addr !== 32'h8) begin
      errors++;
      $display("FAIL stream_first_valid: valid=%b pc=%h instr=%h addr=%h, required 1 0 0 8",
               s_valid, s_pc, s_instr, s_addr);
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (popped.size() != 9) begin
      errors++;
      $display("FAIL stream_throughput: %0d instructions in 9 cycles, required 9", popped.size());
    end
    while (popped.size() != 0) begin
      e = popped.pop_front();
      checks++;
      if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL stream_order: pc=%h instr=%h, required pc=%h instr=%h",
                 e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall();
    logic [63:0] e;
    logic [31:0] hp;
    logic [31:0] hi;
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    hp = s_pc;
    hi = s_instr;
    checks++;
    if (s_valid !== 1'b1 || s_pc !== exp_pc) begin
      errors++;
      $display("FAIL stall_head: valid=%b pc=%h, required 1 %h", s_valid, s_pc, exp_pc);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checks++;
      if (s_valid !== 1'b1 || s_pc !== hp || s_instr !== hi || s_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: valid=%b pc=%h instr=%h req=%b, required 1 %h %h 0",
                 s_valid, s_pc, s_instr, s_req, hp, hi);
      end
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (popped.size() != 6) begin
      errors++;
      $display("FAIL stall_release_count: %0d instructions after stall, required 6", popped.size());
    end
    while (popped.size() != 0) begin
      e = popped.pop_front();
      checks++;
      if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL stall_order: pc=%h instr=%h, required pc=%h instr=%h",
                 e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_gnt_low();
    logic [63:0] e;
    logic [31:0] a0;
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    a0 = s_addr;
    checks++;
    if (s_req !== 1'b1) begin
      errors++;
      $display("FAIL gnt_low_req: req=%b, required 1", s_req);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== a0) begin
        errors++;
        $display("FAIL gnt_low_hold: req=%b addr=%h, required 1 %h", s_req, s_addr, a0);
      end
    end
    while (popped.size() != 0) begin
      e = popped.pop_front();
      checks++;
      if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL gnt_low_order: pc=%h instr=%h, required pc=%h instr=%h",
                 e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
    checks++;
    if (s_valid !== 1'b0 || s_pc !== exp_pc - 32'd4 || s_instr !== mem_word(exp_pc - 32'd4)
        || a0 !== exp_pc) begin
      errors++;
      $display("FAIL gnt_low_drain: valid=%b pc=%h instr=%h addr=%h, required 0 %h %h addr %h",
               s_valid, s_pc, s_instr, a0, exp_pc - 32'd4, mem_word(exp_pc - 32'd4), exp_pc);
    end
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    while (popped.size() != 0) begin
      e = popped.pop_front();
      checks++;
      if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL gnt_resume_order: pc=%h instr=%h, required pc=%h instr=%h",
                 e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    logic [63:0] e;
    int unsigned wait_cnt;
    logic [31:0] targets[4];
    targets = '{32'h0000_0100, 32'h0000_0300, 32'h0000_0080, 32'hFFFF_FFF8};
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, (t == 2) && (i > 0), 1'b1);
      while (popped.size() != 0) begin
        e = popped.pop_front();
        checks++;
        if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL redirect_pre_order: pc=%h instr=%h, required pc=%h instr=%h",
                   e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      // t==1: back-to-back redirects, the second one must win
      if (t == 1) tick(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
      tick(1'b0, 1'b1, targets[t], (t == 2), 1'b1);
      checks++;
      if (s_req !== 1'b0) begin
        errors++;
        $display("FAIL redirect_no_req: req=%b, required 0", s_req);
      end
      exp_pc = targets[t];
      tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (s_valid !== 1'b0) begin
        errors++;
        $display("FAIL redirect_flush: valid=%b, required 0", s_valid);
      end
      wait_cnt = 0;
      while (!s_valid && wait_cnt < 4) begin
        tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        wait_cnt++;
      end
      checks++;
      if (s_valid !== 1'b1 || s_pc !== targets[t]) begin
        errors++;
        $display("FAIL redirect_target: valid=%b pc=%h, required 1 %h", s_valid, s_pc, targets[t]);
      end
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      while (popped.size() != 0) begin
        e = popped.pop_front();
        checks++;
        if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL redirect_order: pc=%h instr=%h, required pc=%h instr=%h",
                   e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] e;
    logic        redir, stall, gnt;
    logic [31:0] tgt;
    logic        prev_redir, prev_hold, prev_wait;
    logic [31:0] hold_pc, hold_instr, wait_addr;
    prev_redir = 1'b0;
    prev_hold  = 1'b0;
    prev_wait  = 1'b0;
    hold_pc    = '0;
    hold_instr = '0;
    wait_addr  = '0;
    for (int i = 0; i < 400; i++) begin
      redir = ($urandom_range(0, 19) == 0);
      stall = ($urandom_range(0, 2) == 0);
      gnt   = ($urandom_range(0, 3) != 0);
`ifdef CORE_IF_MISALIGN_TRAP_EN
      tgt   = 32'($urandom_range(0, 1023)) & 32'h0000_03FC;
`else
      tgt   = 32'($urandom_range(0, 1023));
`endif
      tick(1'b0, redir, tgt, stall, gnt);
      if (prev_redir) begin
        checks++;
        if (s_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_flush: valid=%b, required 0", s_valid);
        end
      end
      if (prev_hold) begin
        checks++;
        if (s_valid !== 1'b1 || s_pc !== hold_pc || s_instr !== hold_instr) begin
          errors++;
          $display("FAIL rand_stall_hold: valid=%b pc=%h instr=%h, required 1 %h %h",
                   s_valid, s_pc, s_instr, hold_pc, hold_instr);
        end
      end
      if (prev_wait) begin
        checks++;
        if (s_addr !== wait_addr) begin
          errors++;
          $display("FAIL rand_addr_hold: addr=%h, required %h", s_addr, wait_addr);
        end
      end
      prev_redir = redir;
      prev_hold  = s_valid & stall & ~redir;
      hold_pc    = s_pc;
      hold_instr = s_instr;
      prev_wait  = s_req & ~gnt & ~redir;
      wait_addr  = s_addr;
      while (popped.size() != 0) begin
        e = popped.pop_front();
        checks++;
        if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rand_order: pc=%h instr=%h, required pc=%h instr=%h",
                   e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (redir) exp_pc = tgt & ~32'h3;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    while (popped.size() != 0) begin
      e = popped.pop_front();
      checks++;
      if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL reset_mid_pre_order: pc=%h instr=%h, required pc=%h instr=%h",
                 e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
    // a response is due in this cycle and must not survive the reset
    tick(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: valid=%b req=%b, required 0 0", s_valid, s_req);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_restart: valid=%b req=%b addr=%h, required 0 1 00000000",
               s_valid, s_req, s_addr);
    end
    exp_pc = 32'h0;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (popped.size() == 0) begin
      errors++;
      $display("FAIL reset_mid_resume: 0 instructions after reset, required at least 1");
    end
    while (popped.size() != 0) begin
      e = popped.pop_front();
      checks++;
      if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL reset_mid_order: pc=%h instr=%h, required pc=%h instr=%h",
                 e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

`ifdef CORE_IF_MISALIGN_TRAP_EN
  task automatic test_misalign();
    logic [63:0] e;
    tick(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b1);
    popped.delete();
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (s_valid !== 1'b1 || s_mis !== 1'b1 || s_pc !== 32'h0000_0102 || s_instr !== 32'h13) begin
      errors++;
      $display("FAIL misalign_entry: valid=%b mis=%b pc=%h instr=%h, required 1 1 00000102 00000013",
               s_valid, s_mis, s_pc, s_instr);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (s_req !== 1'b0 || (i > 0 && s_valid !== 1'b0)) begin
        errors++;
        $display("FAIL misalign_halt: req=%b valid=%b, required 0 0", s_req, s_valid);
      end
    end
    popped.delete();
    tick(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1);
    exp_pc = 32'h0000_0040;
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (popped.size() == 0) begin
      errors++;
      $display("FAIL misalign_resume: 0 instructions after redirect, required at least 1");
    end
    while (popped.size() != 0) begin
      e = popped.pop_front();
      checks++;
      if (e[63:32] !== exp_pc || e[31:0] !== mem_word(exp_pc)) begin
        errors++;
        $display("FAIL misalign_order: pc=%h instr=%h, required pc=%h instr=%h",
                 e[63:32], e[31:0], exp_pc, mem_word(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_id_stall    = 1'b0;
    bus.i_ibus_rd_gnt = 1'b1;
    exp_pc            = '0;
    test_reset();
    test_stream();
    test_stall();
    test_gnt_low();
    test_redirect();
    test_random();
    test_reset_mid();
`ifdef CORE_IF_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
